// File: rtl/eta_seq_multiplier.sv
// eta_seq_multiplier
//
// Iterative shift-and-add unsigned multiplier. One multiplier bit is retired
// per clock. Each partial-product accumulation uses an error-tolerant adder:
// the upper segment is an exact add with no carry-in from below, and the low
// SPLIT bits use an approximate XOR/saturate rule with no carry chain at all.
//
// Parameters
//   WIDTH  operand width; product is 2*WIDTH bits
//   SPLIT  number of low product bits accumulated approximately (0..2*WIDTH,
//          0 gives an exact multiplier)
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous active-high reset
//   start    request a multiply; sampled only while idle
//   a        multiplicand, captured at the accepted start
//   b        multiplier, captured at the accepted start
//   busy     high whenever the block is not idle
//   done     one-cycle pulse, product valid while high
//   product  registered result, held until the next done

module eta_seq_multiplier #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPLIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [CntW-1:0]  cnt_q;
  logic [PW-1:0]    product_q;

  logic             last_bit;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;

  // Upper segment: exact add of the fields above SPLIT. The low segment's
  // carry is never propagated in, and the carry-out falls off the top when
  // the sum is shifted back into place.
  function automatic logic [PW-1:0] eta_upper(input logic [PW-1:0] x,
                                              input logic [PW-1:0] y);
    logic [PW-1:0] hi_x;
    logic [PW-1:0] hi_y;
    hi_x = x >> SPLIT;
    hi_y = y >> SPLIT;
    return (hi_x + hi_y) << SPLIT;
  endfunction

  // Lower segment: scanning from the top of the segment, bits are XORed
  // until the first position where both inputs are 1; that bit and every
  // bit below it saturate to 1. Bits at or above SPLIT are returned as 0.
  function automatic logic [PW-1:0] eta_lower(input logic [PW-1:0] x,
                                              input logic [PW-1:0] y);
    logic [PW-1:0] res;
    logic          sat;
    res = '0;
    sat = 1'b0;
    for (int i = int'(PW) - 1; i >= 0; i--) begin
      if (i < int'(SPLIT)) begin
        if (sat || (x[i] && y[i])) begin
          sat    = 1'b1;
          res[i] = 1'b1;
        end else begin
          res[i] = x[i] ^ y[i];
        end
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] eta_add(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y);
    // The two segments occupy disjoint bit ranges, so OR merges them.
    return eta_upper(x, y) | eta_lower(x, y);
  endfunction

  // Datapath: shifted multiplicand for the current bit and the next
  // accumulator value. Only meaningful while running.
  always_comb begin
    last_bit = (cnt_q == CntW'(WIDTH - 1));
    addend   = PW'(a_q) << cnt_q;
    acc_next = b_q[cnt_q] ? eta_add(acc_q, addend) : acc_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RUN always lasts exactly WIDTH cycles; there is no
  // early exit on zero multiplier bits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode directly from the registered state, so they are glitch-free.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign product = product_q;

  // Operand capture, accumulation and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CntW'(1);
          // Publish the accumulator including the final bit's contribution.
          if (last_bit) begin
            product_q <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eta_seq_multiplier.sv
// Bench for eta_seq_multiplier: one approximate (SPLIT=8) and one exact
// (SPLIT=0) instance share stimulus. A behavioural model predicts busy/done/
// product every cycle; directed tests add literal expectations.

module tb_eta_seq_multiplier;

  localparam int unsigned W        = 8;
  localparam int unsigned SPLIT_AP = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;

  logic          busy_ap, done_ap, busy_ex, done_ex;
  logic [15:0]   product_ap, product_ex;

  int tests_run;
  int tests_failed;

  eta_seq_multiplier #(.WIDTH(W), .SPLIT(SPLIT_AP)) dut_ap (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy_ap),
    .done    (done_ap),
    .product (product_ap)
  );

  eta_seq_multiplier #(.WIDTH(W), .SPLIT(0)) dut_ex (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy_ex),
    .done    (done_ex),
    .product (product_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ETA add from its arithmetic description: exact upper sum with no carry-in,
  // lower field is x^y with everything from the highest double-one position
  // downward forced to 1.
  function automatic logic [15:0] model_eta(input logic [15:0] x, input logic [15:0] y,
                                            input int s);
    logic [31:0] up, lowmask, g, lo;
    int          msb;
    up      = (({16'd0, x} >> s) + ({16'd0, y} >> s)) << s;
    lowmask = (32'd1 << s) - 32'd1;
    g       = {16'd0, x & y} & lowmask;
    lo      = {16'd0, x ^ y} & lowmask;
    if (g != 0) begin
      msb = 0;
      for (int k = 0; k < s; k++) if (g[k]) msb = k;
      lo = lo | ((32'd1 << (msb + 1)) - 32'd1);
    end
    return up[15:0] | lo[15:0];
  endfunction

  function automatic logic [15:0] model_mul(input int s, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] acc;
    acc = 16'd0;
    for (int j = 0; j < 8; j++) if (y[j]) acc = model_eta(acc, {8'd0, x} << j, s);
    return acc;
  endfunction

  // Transaction-level timing model: cycles remaining until idle.
  int          m_left;
  logic [15:0] m_pend_ap, m_pend_ex, m_prod_ap, m_prod_ex;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left    <= 0;
      m_pend_ap <= '0;
      m_pend_ex <= '0;
      m_prod_ap <= '0;
      m_prod_ex <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left    <= W + 1;
        m_pend_ap <= model_mul(SPLIT_AP, a, b);
        m_pend_ex <= model_mul(0, a, b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_prod_ap <= m_pend_ap;
        m_prod_ex <= m_pend_ex;
      end
    end
  end

  always @(negedge clk) begin
    check("busy_ap",    {31'd0, busy_ap}, {31'd0, m_left != 0});
    check("done_ap",    {31'd0, done_ap}, {31'd0, m_left == 1});
    check("product_ap", {16'd0, product_ap}, {16'd0, m_prod_ap});
    check("busy_ex",    {31'd0, busy_ex}, {31'd0, m_left != 0});
    check("done_ex",    {31'd0, done_ex}, {31'd0, m_left == 1});
    check("product_ex", {16'd0, product_ex}, {16'd0, m_prod_ex});
  end

  // Wait (bounded) for done; returns edges counted since the call.
  task automatic wait_done(output int n);
    n = 0;
    while (!done_ap && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp_ap, input logic [15:0] exp_ex);
    int n;
    @(posedge clk);
    #1;
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);  // start edge E0
    #1;
    start = 1'b0;
    wait_done(n);
    check({name, " latency"}, n, W);
    check({name, " done_ex"}, {31'd0, done_ex}, 32'd1);
    check({name, " prod_ap"}, {16'd0, product_ap}, {16'd0, exp_ap});
    check({name, " prod_ex"}, {16'd0, product_ex}, {16'd0, exp_ex});
    @(posedge clk);
    #1;
    check({name, " done low"}, {31'd0, done_ap}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    logic [7:0]  ra, rb;
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Asynchronous reset with no clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst busy",    {31'd0, busy_ap}, 32'd0);
    check("rst done",    {31'd0, done_ap}, 32'd0);
    check("rst product", {16'd0, product_ap}, 32'd0);
    check("rst prod_ex", {16'd0, product_ex}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("3x3",     8'h03, 8'h03, 16'h0007, 16'h0009);
    run_op("10x10",   8'h10, 8'h10, 16'h0100, 16'h0100);
    run_op("ffx01",   8'hFF, 8'h01, 16'h00FF, 16'h00FF);
    run_op("00xff",   8'h00, 8'hFF, 16'h0000, 16'h0000);
    run_op("ffxff",   8'hFF, 8'hFF, model_mul(SPLIT_AP, 8'hFF, 8'hFF), 16'hFE01);
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op("rand", ra, rb, model_mul(SPLIT_AP, ra, rb), 16'(ra) * 16'(rb));
    end

    // Continuous start: one product every W+2 cycles.
    @(posedge clk);
    #1;
    a     = 8'd2;
    b     = 8'd5;
    start = 1'b1;
    wait_done(n);
    check("hold first prod", {16'd0, product_ap}, 32'd10);
    @(posedge clk);
    #1;
    wait_done(n);
    check("hold spacing", n + 1, W + 2);
    check("hold prod_ex", {16'd0, product_ex}, 32'd10);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Start pulse during RUN is ignored.
    a     = 8'd3;
    b     = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("ignore latency", n + 4, W);
    check("ignore prod_ap", {16'd0, product_ap}, 32'd7);
    check("ignore prod_ex", {16'd0, product_ex}, 32'd9);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-run at E4, then confirm no done ever arrives for it.
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    a     = 8'd3;
    b     = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy_ex}, 32'd0);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done_ap || done_ex) n++;
    end
    check("abort no done", n, 0);
    check("abort product", {16'd0, product_ex}, 32'd0);
    run_op("post-abort", 8'h03, 8'h03, 16'h0007, 16'h0009);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eta_seq_multiplier.md
# eta_seq_multiplier

Iterative shift-and-add unsigned multiplier that produces the partial-product sums consumed by the approximate-multiplier datapath. Accumulation uses an error-tolerant adder (ETA-I): the upper bits of each add are exact, and the lower `SPLIT` bits are approximate. One multiplier bit is processed per clock. A start/busy/done handshake connects it to the surrounding controller. The block trades accuracy for a short carry chain in the low segment and is the sequential front end of the approximate multiplier.

## Interface
- `WIDTH`, default 8: operand width; the product is `2*WIDTH` bits.
- `SPLIT`, default 8: number of low product bits accumulated approximately. Legal range is 0..`2*WIDTH`. 0 gives an exact multiplier.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a multiply. Sampled only in IDLE.
- `a`, input, `WIDTH`: multiplicand. Captured at the accepted start.
- `b`, input, `WIDTH`: multiplier. Captured at the accepted start.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse; `product` is valid while it is high.
- `product`, output, `2*WIDTH`: registered result. Holds its value until the next done.

## Operation
- **States.** IDLE, RUN, DONE.
- **IDLE.**
  - If `start`=1 at an edge: capture `a` and `b`, clear acc to 0, clear bit counter cnt to 0, go to RUN.
  - Otherwise stay in IDLE.
- **RUN.** At each edge:
  - If b_reg[cnt]=1: acc <= eta_add(acc, a_reg << cnt). Otherwise acc is unchanged.
  - cnt increments by 1.
  - After processing cnt=`WIDTH`-1:
    - `product` <= the updated acc value, i.e. the result including bit `WIDTH`-1.
    - `done` <= 1.
    - go to DONE.
- **DONE.** At the next edge: `done` <= 0, go to IDLE.
- **start while not IDLE.** Ignored in RUN and DONE. No queuing, and captured operands are unaffected.
- **eta_add(x, y)**, with x and y each `2*WIDTH` bits:
  - Upper segment, bits [2*WIDTH-1:SPLIT]: exact sum of x and y upper fields. Carry-in is 0 (no carry from the lower segment). Carry-out is discarded.
  - Lower segment, bits [SPLIT-1:0]: scan from bit SPLIT-1 down to 0.
    - Each result bit is x[i]^y[i] until the first position k where x[k]=y[k]=1.
    - Bit k and all bits below k are forced to 1.
    - If no such k exists, the lower result is simply x^y.
- **Width rule.** With SPLIT=0 the lower segment is empty and the result is the exact product. Because the upper segment drops the low-segment carry, `product` never exceeds `2*WIDTH` bits. No overflow output is needed.

## Timing
- **Reset values.** `busy`=0, `done`=0, `product`=0. Internally: state=IDLE, acc=0, cnt=0, a_reg=0, b_reg=0.
- **Reset mid-operation.** Asserting `rst` in RUN or DONE immediately returns the block to the reset values. No `done` is produced for the aborted operation.
- **Latency for start accepted at edge E0:**
  - `busy` is high from after E0 until after E(`WIDTH`+1).
  - RUN edges are E1..E`WIDTH`.
  - `done` and the new `product` appear after E`WIDTH`.
  - `done` falls after E(`WIDTH`+1).
  - For `WIDTH`=8: `done` is high in the cycle following E8, and the total is 9 cycles start-to-done.
- **Back-to-back throughput.** A new start is accepted at the earliest at E(`WIDTH`+2), the first edge back in IDLE. This gives one product per `WIDTH`+2 cycles.
- **No zero-skipping.** RUN always takes exactly `WIDTH` cycles, whatever the operand values.

## Test plan
- **Reset.** Assert `rst` asynchronously with no clock edge -> `busy`=0, `done`=0, `product`=0 immediately.
- **Approximate vs exact, a=3, b=3, WIDTH=8.**
  - SPLIT=8 -> `product`=7 (the add of 3 and 6 has both bits 1 at position 1, forcing bits 1..0 high).
  - SPLIT=0 -> `product`=9.
  - In both cases `done` pulses exactly 8 edges after the start edge.
- **Single-bit and edge operands, SPLIT=8.**
  - a=0x10, b=0x10 -> `product`=0x0100.
  - a=0xFF, b=0x01 -> `product`=0x00FF.
  - a=0x00, b=0xFF -> `product`=0x0000.
  - `done` asserts for exactly 1 cycle each time.
- **Exact mode sweep, SPLIT=0.** a=0xFF, b=0xFF -> `product`=0xFE01. Random operands match a*b exactly.
- **Handshake.**
  - Hold `start`=1 continuously with a=2, b=5 -> products of 10 are spaced 10 cycles apart.
  - Pulse `start` with new operands during RUN -> ignored, and the original product is still delivered.
- **Reset mid-run.**
  - Assert `rst` at RUN edge E4 -> no `done`, `product` stays 0.
  - Then start with a=3, b=3 (SPLIT=0) -> `product`=9 after 8 RUN edges.
